input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Multi-channel debouncer for raw board inputs (push-buttons, switches) of the associative buffer front panel.
- Sits directly upstream of the edge detector stage: it synchronises each asynchronous input to clk and releases a level change only after it has been stable for STABLE_CYCLES clocks.
- The edge detector therefore sees clean, glitch-free, clk-synchronous levels.

Parameters:
- SIGNAL_NUM, 8, number of independent input channels.
- STABLE_CYCLES, 16, consecutive clk cycles a synchronised level must differ from the output before the output follows it. Must be >= 1.
- CNT_WIDTH, local (not overridable), $clog2(STABLE_CYCLES) with a minimum of 1. Width of each channel counter.

Ports:
- rst, input, 1, asynchronous active-low reset.
- clk, input, 1, system clock. All state updates on posedge.
- signal_input, input, SIGNAL_NUM, raw asynchronous inputs; any bit may toggle at any time.
- signal_output, output, SIGNAL_NUM, debounced registered levels; feed the edge detector.
- busy, output, SIGNAL_NUM, per channel: 1 while the counter is non-zero (a candidate change is being qualified).

Behaviour:
- Reset: rst is asynchronous and active-low; clock is clk.
  - On rst low, clear immediately: both synchroniser stages, all counters, signal_output and busy go to 0.
  - Reset to 0 matches the downstream edge detector's reset state, so no false edge is produced after reset release.
- Synchroniser: per bit, a two-flop chain sync0 <= signal_input, then sync1 <= sync0. Only sync1 is used by the logic.
- Per-channel rule, evaluated at each posedge clk:
  - sync1 == out: cnt <= 0, out holds.
  - sync1 != out and cnt == STABLE_CYCLES-1: out <= sync1, cnt <= 0.
  - sync1 != out otherwise: cnt <= cnt + 1.
- Latency:
  - Input settled before edge k gives sync1 valid after edge k+1.
  - out changes at edge k+1+STABLE_CYCLES.
  - With STABLE_CYCLES=1, out changes at edge k+2.
- Glitch rejection:
  - Any return of sync1 to out before qualification clears cnt.
  - A pulse lasting fewer than STABLE_CYCLES synchronised cycles never reaches out.
  - A later change restarts counting from 0.
- Channels are fully independent. Simultaneous changes on several bits qualify in parallel with identical latency.
- Counter never wraps: maximum value is STABLE_CYCLES-1, then it clears on qualification.
- busy = (cnt != 0), registered implicitly via cnt. It is 0 on the cycle out updates.
- Reset asserted mid-qualification aborts the qualification.
  - After release, the first sync1 differing from 0 starts counting from 0.
  - An input held at 1 through reset is re-qualified, with full latency measured from the first post-reset edge.
- No combinational path from signal_input to any output.

Decomposition:
- No shared package needed. CNT_WIDTH is a local constant; STABLE_CYCLES is passed down.
- One sub-module, debounce_channel (1-bit sync chain, counter, out register, busy).
  - Instantiated SIGNAL_NUM times in a generate loop.
  - Top level only wires buses.

Test Plan (STABLE_CYCLES=4, SIGNAL_NUM=8):
- Reset: hold rst=0 with signal_input=8'hFF -> signal_output=8'h00, busy=8'h00. After release, signal_output=8'hFF at the 6th posedge, busy=8'hFF during the intervening qualification cycles.
- Clean press: bit0 rises before edge k and stays high -> signal_output[0] rises exactly at edge k+5. Other bits stay 0.
- Glitch: bit1 high for 3 clk cycles, then low -> signal_output[1] stays 0, busy[1] pulses, then returns to 0.
- Bounce: bit2 toggles 1,0,1,0,1 each cycle, then stays 1 -> exactly one rising transition on signal_output[2], 5 edges after the final stable 1 is sampled.
- Parallel channels: signal_input 8'h00 -> 8'hA5 in one cycle -> signal_output becomes 8'hA5 in a single cycle at edge k+5. Release to 8'h00 -> 8'h00 after the same latency.
- Reset mid-count: bit3 high, rst pulsed low after 2 counting cycles -> signal_output[3]=0 and busy[3]=0 immediately. Output rises 5 edges after the first post-release edge.

Source files
------------

// File: rtl/debounce_channel.sv
// debounce_channel
//   One debouncer lane: two-flop synchroniser, a stability counter and the
//   registered output level. The output follows the synchronised input only
//   after the input has differed from it for STABLE_CYCLES consecutive clocks.
//
// Ports
//   rst           async active-low reset
//   clk           clock
//   signal_input  raw asynchronous level
//   signal_output debounced, clk-synchronous level
//   busy          1 while a candidate change is being qualified (cnt != 0)
module debounce_channel #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic rst,
    input  logic clk,
    input  logic signal_input,
    output logic signal_output,
    output logic busy
);

    localparam int CNT_WIDTH = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync0;
    logic                 sync1;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0         <= 1'b0;
            sync1         <= 1'b0;
            cnt           <= '0;
            signal_output <= 1'b0;
        end else begin
            sync0 <= signal_input;
            sync1 <= sync0;
            // Any return to the current output level discards the candidate,
            // so short pulses never accumulate across separate glitches.
            if (sync1 == signal_output) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                signal_output <= sync1;
                cnt           <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Derived from a register only; no path from signal_input.
    assign busy = (cnt != '0);

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer
//   Multi-channel debouncer for front-panel buttons/switches. Each bit is an
//   independent debounce_channel; this level only fans the buses out/in.
//
// Ports
//   rst           async active-low reset
//   clk           clock
//   signal_input  [SIGNAL_NUM] raw asynchronous inputs
//   signal_output [SIGNAL_NUM] debounced levels for the edge detector
//   busy          [SIGNAL_NUM] per-channel qualification in progress
module input_debouncer #(
    parameter int SIGNAL_NUM    = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic [SIGNAL_NUM-1:0] signal_input,
    output logic [SIGNAL_NUM-1:0] signal_output,
    output logic [SIGNAL_NUM-1:0] busy
);

    for (genvar g = 0; g < SIGNAL_NUM; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .rst          (rst),
            .clk          (clk),
            .signal_input (signal_input[g]),
            .signal_output(signal_output[g]),
            .busy         (busy[g])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    typedef struct {
        logic       rst;
        logic [7:0] in;
        logic [7:0] out;
        logic [7:0] bsy;
    } vec_t;

    logic       rst;
    logic       clk;
    logic [7:0] signal_input;
    logic [7:0] signal_output;
    logic [7:0] busy;

    int nvec = 0;
    int nbad = 0;

    input_debouncer #(
        .SIGNAL_NUM   (8),
        .STABLE_CYCLES(4)
    ) dut (
        .rst          (rst),
        .clk          (clk),
        .signal_input (signal_input),
        .signal_output(signal_output),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];

    function automatic void addv(logic r, logic [7:0] i, logic [7:0] o, logic [7:0] b);
        vec_t v;
        v.rst = r; v.in = i; v.out = o; v.bsy = b;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [7:0] o, logic [7:0] b);
        nvec++;
        if (signal_output !== o || busy !== b) begin
            nbad++;
            $display("FAIL %s: got out=%h busy=%h, expected out=%h busy=%h",
                     name, signal_output, busy, o, b);
        end
    endtask

    // Drive inputs, let one posedge pass, then sample 1 time unit later.
    task automatic cyc(string name, logic r, logic [7:0] i, logic [7:0] o, logic [7:0] b);
        rst          = r;
        signal_input = i;
        @(posedge clk);
        #1;
        chk(name, o, b);
    endtask

    initial begin
        int rises;
        logic prev;
        logic [9:0] bnc_in;
        logic [9:0] bnc_busy;

        rst          = 1'b0;
        signal_input = 8'hFF;

        // Reset with inputs high, then re-qualification (out at 6th edge).
        addv(0, 8'hFF, 8'h00, 8'h00);
        addv(0, 8'hFF, 8'h00, 8'h00);
        addv(1, 8'hFF, 8'h00, 8'h00);  // edge1: sync0
        addv(1, 8'hFF, 8'h00, 8'h00);  // edge2: sync1
        addv(1, 8'hFF, 8'h00, 8'hFF);  // edge3: cnt=1
        addv(1, 8'hFF, 8'h00, 8'hFF);
        addv(1, 8'hFF, 8'h00, 8'hFF);
        addv(1, 8'hFF, 8'hFF, 8'h00);  // edge6: out
        // All released, k+5 latency.
        addv(1, 8'h00, 8'hFF, 8'h00);
        addv(1, 8'h00, 8'hFF, 8'h00);
        addv(1, 8'h00, 8'hFF, 8'hFF);
        addv(1, 8'h00, 8'hFF, 8'hFF);
        addv(1, 8'h00, 8'hFF, 8'hFF);
        addv(1, 8'h00, 8'h00, 8'h00);
        // Parallel channels 00 -> A5.
        addv(1, 8'hA5, 8'h00, 8'h00);
        addv(1, 8'hA5, 8'h00, 8'h00);
        addv(1, 8'hA5, 8'h00, 8'hA5);
        addv(1, 8'hA5, 8'h00, 8'hA5);
        addv(1, 8'hA5, 8'h00, 8'hA5);
        addv(1, 8'hA5, 8'hA5, 8'h00);
        // Release A5 -> 00.
        addv(1, 8'h00, 8'hA5, 8'h00);
        addv(1, 8'h00, 8'hA5, 8'h00);
        addv(1, 8'h00, 8'hA5, 8'hA5);
        addv(1, 8'h00, 8'hA5, 8'hA5);
        addv(1, 8'h00, 8'hA5, 8'hA5);
        addv(1, 8'h00, 8'h00, 8'h00);
        // Clean press on bit0 only.
        addv(1, 8'h01, 8'h00, 8'h00);
        addv(1, 8'h01, 8'h00, 8'h00);
        addv(1, 8'h01, 8'h00, 8'h01);
        addv(1, 8'h01, 8'h00, 8'h01);
        addv(1, 8'h01, 8'h00, 8'h01);
        addv(1, 8'h01, 8'h01, 8'h00);
        addv(1, 8'h01, 8'h01, 8'h00);

        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].in, tbl[i].out, tbl[i].bsy);

        // Glitch: bit1 high for 3 cycles gives cnt 1,2,3 then clears.
        cyc("glitch0", 1, 8'h03, 8'h01, 8'h00);
        cyc("glitch1", 1, 8'h03, 8'h01, 8'h00);
        cyc("glitch2", 1, 8'h03, 8'h01, 8'h02);
        cyc("glitch3", 1, 8'h01, 8'h01, 8'h02);
        cyc("glitch4", 1, 8'h01, 8'h01, 8'h02);
        cyc("glitch5", 1, 8'h01, 8'h01, 8'h00);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("glitch_hold%0d", i), 1, 8'h01, 8'h01, 8'h00);

        // Bounce on bit2: 1,0,1,0,1 then steady 1. Out rises once at cycle 9.
        bnc_in   = 10'b11_1111_0101;  // bit i = value driven before cycle i
        bnc_busy = 10'b01_1101_0100;
        rises    = 0;
        prev     = signal_output[2];
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("bounce%0d", i), 1, {5'b0, bnc_in[i], 2'b01},
                (i == 9) ? 8'h05 : 8'h01, {5'b0, bnc_busy[i], 2'b00});
            if (!prev && signal_output[2]) rises++;
            prev = signal_output[2];
        end
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("bounce_hold%0d", i), 1, 8'h05, 8'h05, 8'h00);
            if (!prev && signal_output[2]) rises++;
            prev = signal_output[2];
        end
        nvec++;
        if (rises != 1) begin
            nbad++;
            $display("FAIL bounce_rises: got %0d rising transitions, expected 1", rises);
        end

        // Reset mid-count on bit3, after two counting cycles.
        cyc("rmid0", 1, 8'h0D, 8'h05, 8'h00);
        cyc("rmid1", 1, 8'h0D, 8'h05, 8'h00);
        cyc("rmid2", 1, 8'h0D, 8'h05, 8'h08);
        cyc("rmid3", 1, 8'h0D, 8'h05, 8'h08);
        rst = 1'b0;
        #1;
        chk("rmid_async", 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("rmid_held", 8'h00, 8'h00);
        // First post-release edge is r; output at r+5.
        cyc("rmid_r0", 1, 8'h0D, 8'h00, 8'h00);
        cyc("rmid_r1", 1, 8'h0D, 8'h00, 8'h00);
        cyc("rmid_r2", 1, 8'h0D, 8'h00, 8'h0D);
        cyc("rmid_r3", 1, 8'h0D, 8'h00, 8'h0D);
        cyc("rmid_r4", 1, 8'h0D, 8'h00, 8'h0D);
        cyc("rmid_r5", 1, 8'h0D, 8'h0D, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
